// File: rtl/grostl_sub_bytes_iter.sv
// grostl_sub_bytes_iter
//   Iterative SubBytes stage for the Groestl-512 P/Q round. A 64-byte state is
//   loaded into one register and substituted in place, SBOX_COUNT bytes per
//   cycle, in ascending byte order. The result is presented downstream behind
//   a valid/ready handshake.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; din sampled only on the handshake edge
//   din                 input state, row-major, byte i = 8*row + col
//   out_valid/out_ready output handshake; dout held while out_ready is low
//   dout                substituted state, driven straight from the state register

// One S-box lane: GF(2^8) inverse (as x^254) followed by the AES affine map.
module grostl_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(logic [7:0] x, logic [7:0] y);
    logic [7:0] p, t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x12, x14, x15, x240, inv;

  // Addition chain for x^254; zero maps to zero as the S-box requires.
  always_comb begin
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x14  = gmul(x12, x2);
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    inv  = gmul(x240, x14);
  end

  always_comb begin
    s = '0;
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
    s = s ^ 8'h63;
  end
endmodule

module grostl_sub_bytes_iter #(
  parameter int SBOX_COUNT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:7][0:7][7:0]   din,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:7][0:7][7:0]   dout
);
  localparam int N  = 64 / SBOX_COUNT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (SBOX_COUNT != 1 && SBOX_COUNT != 2 && SBOX_COUNT != 4 && SBOX_COUNT != 8 &&
        SBOX_COUNT != 16 && SBOX_COUNT != 32 && SBOX_COUNT != 64) begin : g_bad_param
      $error("grostl_sub_bytes_iter: SBOX_COUNT must be a power of two from 1 to 64");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} st_t;

  st_t                          st, st_nxt;
  logic [CW-1:0]                cnt, cnt_nxt;
  logic                         ld, sub;
  logic [0:63][7:0]             sreg;
  logic [5:0]                   base;
  logic [SBOX_COUNT-1:0][7:0]   sb_in, sb_out;

  // First byte of the group being substituted this cycle.
  assign base = 6'(int'(cnt) * SBOX_COUNT);

  genvar g;
  generate
    for (g = 0; g < SBOX_COUNT; g++) begin : g_lane
      assign sb_in[g] = sreg[base + 6'(g)];
      grostl_sbox u_sbox (.a(sb_in[g]), .s(sb_out[g]));
    end
  endgenerate

  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    ld        = 1'b0;
    sub       = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld      = 1'b1;
          cnt_nxt = '0;
          st_nxt  = BUSY;
        end
      end
      BUSY: begin
        sub = 1'b1;
        if (cnt == LAST) begin
          cnt_nxt = '0;
          st_nxt  = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Downstream taking dout frees the register, so a new state can load
        // on the same edge without a bubble.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            ld      = 1'b1;
            cnt_nxt = '0;
            st_nxt  = BUSY;
          end else begin
            st_nxt  = IDLE;
          end
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= IDLE;
      cnt  <= '0;
      sreg <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      if (ld)
        sreg <= din;
      else if (sub)
        for (int k = 0; k < SBOX_COUNT; k++)
          sreg[base + 6'(k)] <= sb_out[k];
    end
  end

  assign dout = sreg;
endmodule

// File: tb/tb_grostl_sub_bytes_iter.sv
module tb_grostl_sub_bytes_iter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  // Index 0: SBOX_COUNT=8, index 1: SBOX_COUNT=1, index 2: SBOX_COUNT=64.
  logic [2:0]        iv, ir, ov, ordy;
  logic [2:0][511:0] dinv, doutv;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb_tab [256];

  always #5 clk = ~clk;

  grostl_sub_bytes_iter #(.SBOX_COUNT(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .din(dinv[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .dout(doutv[0]));
  grostl_sub_bytes_iter #(.SBOX_COUNT(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .din(dinv[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .dout(doutv[1]));
  grostl_sub_bytes_iter #(.SBOX_COUNT(64)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .din(dinv[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .dout(doutv[2]));

  // Reference: polynomial product reduced by long division mod 0x11b.
  function automatic logic [7:0] gmul_ref(logic [7:0] a, logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h11b) << (i - 8));
    return p[7:0];
  endfunction

  // S-box table: brute-force inverse, then b ^ rotl1..4(b) ^ 0x63.
  task automatic init_table();
    logic [7:0]  inv;
    logic [15:0] d;
    logic [7:0]  s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul_ref(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ 8'h63;
      for (int k = 1; k <= 4; k++) begin
        d = {inv, inv} << k;
        s = s ^ d[15:8];
      end
      sb_tab[x] = s;
    end
  endtask

  function automatic logic [511:0] sub_model(logic [511:0] v);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[511 - 8*i -: 8] = sb_tab[v[511 - 8*i -: 8]];
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts clock edges from the handshake edge (inclusive) until out_valid.
  task automatic run_one(input int d, input logic [511:0] v, output int lat);
    iv[d] = 1'b1; dinv[d] = v; ordy[d] = 1'b1;
    @(posedge clk); lat = 1; @(negedge clk);
    iv[d] = 1'b0; dinv[d] = rand512();
    while (!ov[d] && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int d);
    int c = 0;
    while (!ov[d] && c < 200) begin tick(); c++; end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (ov[d] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid[%0d] got %b want 0", d, ov[d]); end
      n_cmp++; if (ir[d] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready[%0d] got %b want 1", d, ir[d]); end
      n_cmp++; if (doutv[d] !== '0) begin n_err++; $display("FAIL reset_dout[%0d] got %h want 0", d, doutv[d]); end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    int lat;
    run_one(0, '0, lat);
    n_cmp++; if (lat != 9) begin n_err++; $display("FAIL zero_latency got %0d want 9", lat); end
    n_cmp++; if (doutv[0] !== {64{8'h63}}) begin n_err++; $display("FAIL zero_dout got %h want all 63", doutv[0]); end
    tick();
    n_cmp++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_err++; $display("FAIL zero_back_to_idle got ov=%b ir=%b want ov=0 ir=1", ov[0], ir[0]);
    end
  endtask

  task automatic test_sizes();
    int lat;
    int want_lat [3] = '{9, 65, 2};
    logic [511:0] v, exp;
    for (int i = 0; i < 64; i++) v[511 - 8*i -: 8] = 8'(i);
    exp = sub_model(v);
    for (int d = 0; d < 3; d++) begin
      run_one(d, v, lat);
      n_cmp++; if (lat != want_lat[d]) begin n_err++; $display("FAIL sizes_latency[%0d] got %0d want %0d", d, lat, want_lat[d]); end
      n_cmp++; if (doutv[d] !== exp) begin n_err++; $display("FAIL sizes_dout[%0d] got %h want %h", d, doutv[d], exp); end
      n_cmp++; if (doutv[d][511:480] !== 32'h637c777b) begin
        n_err++; $display("FAIL sizes_head[%0d] got %h want 637c777b", d, doutv[d][511:480]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [511:0] v, exp, hold_rnd;
    int bad = 0;
    v = {64{8'hff}}; v[511 - 8*21 -: 8] = 8'h53;
    exp = {64{8'h16}}; exp[511 - 8*21 -: 8] = 8'hed;
    iv[0] = 1'b1; dinv[0] = v; ordy[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    wait_valid(0);
    n_cmp++; if (doutv[0] !== exp) begin n_err++; $display("FAIL stall_dout got %h want %h", doutv[0], exp); end
    iv[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      hold_rnd = rand512(); dinv[0] = hold_rnd;
      #1;
      n_cmp++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || doutv[0] !== exp) begin
        n_err++; bad++;
        $display("FAIL stall_hold cycle %0d got ov=%b ir=%b dout=%h want ov=1 ir=0 dout=%h", c, ov[0], ir[0], doutv[0], exp);
      end
      tick();
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    tick();
    n_cmp++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_err++; $display("FAIL stall_release got ov=%b ir=%b want ov=0 ir=1", ov[0], ir[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] a, b;
    int lat;
    a = rand512(); b = rand512();
    iv[0] = 1'b1; dinv[0] = a; ordy[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    wait_valid(0);
    ordy[0] = 1'b1; iv[0] = 1'b1; dinv[0] = b;
    #1;
    n_cmp++; if (ir[0] !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got %b want 1", ir[0]); end
    n_cmp++; if (doutv[0] !== sub_model(a)) begin n_err++; $display("FAIL b2b_first got %h want %h", doutv[0], sub_model(a)); end
    @(posedge clk); lat = 1; @(negedge clk);
    iv[0] = 1'b0; dinv[0] = rand512();
    n_cmp++; if (ov[0] !== 1'b0 || ir[0] !== 1'b0) begin
      n_err++; $display("FAIL b2b_busy got ov=%b ir=%b want ov=0 ir=0", ov[0], ir[0]);
    end
    while (!ov[0] && lat < 200) begin @(posedge clk); lat++; @(negedge clk); end
    n_cmp++; if (lat != 9) begin n_err++; $display("FAIL b2b_latency got %0d want 9", lat); end
    n_cmp++; if (doutv[0] !== sub_model(b)) begin n_err++; $display("FAIL b2b_second got %h want %h", doutv[0], sub_model(b)); end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [511:0] a, b;
    int lat;
    logic saw = 1'b0;
    a = rand512(); b = rand512();
    iv[0] = 1'b1; dinv[0] = a; ordy[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    repeat (3) tick();                 // step counter now at 3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || doutv[0] !== '0) begin
      n_err++; $display("FAIL abort_state got ov=%b ir=%b dout=%h want ov=0 ir=1 dout=0", ov[0], ir[0], doutv[0]);
    end
    for (int c = 0; c < 12; c++) begin if (ov[0]) saw = 1'b1; tick(); end
    n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL abort_no_valid got out_valid=1 want 0"); end
    run_one(0, b, lat);
    n_cmp++; if (lat != 9) begin n_err++; $display("FAIL abort_next_latency got %0d want 9", lat); end
    n_cmp++; if (doutv[0] !== sub_model(b)) begin n_err++; $display("FAIL abort_next_dout got %h want %h", doutv[0], sub_model(b)); end
    tick();
  endtask

  task automatic test_random();
    logic [511:0] q [$];
    logic [511:0] exp;
    int accepted = 0, got = 0, cyc = 0;
    while ((accepted < 1000 || q.size() != 0) && cyc < 60000) begin
      iv[0]   = (accepted < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      dinv[0] = rand512();
      ordy[0] = ($urandom_range(0, 3) != 0);
      #1;
      if (iv[0] && ir[0]) begin q.push_back(sub_model(dinv[0])); accepted++; end
      if (ov[0] && ordy[0]) begin
        exp = (q.size() != 0) ? q.pop_front() : 'x;
        n_cmp++;
        if (doutv[0] !== exp) begin
          n_err++; $display("FAIL random_state %0d got %h want %h", got, doutv[0], exp);
        end
        got++;
      end
      tick();
      cyc++;
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    n_cmp++; if (got != 1000 || q.size() != 0) begin
      n_err++; $display("FAIL random_count got %0d outputs (%0d pending) want 1000 (0 pending)", got, q.size());
    end
    tick();
  endtask

  initial begin
    iv = '0; ordy = '0; dinv = '0;
    init_table();
    repeat (2) tick();
    test_reset();
    test_zero();
    test_sizes();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/grostl_sub_bytes_iter.md
# grostl_sub_bytes_iter

Iterative SubBytes stage for the Grøstl-512 P/Q round datapath. It sits directly upstream of the ShiftBytes stage. It accepts a 64-byte state, applies the AES S-box to every byte over several cycles using SBOX_COUNT S-box instances, and presents the substituted state to ShiftBytes behind a valid/ready handshake. The narrow S-box count lets the DPA designs trade latency for area and leakage profile.

## Interface
- SBOX_COUNT, 8, S-boxes evaluated per cycle. Legal values: 1, 2, 4, 8, 16, 32, 64. Any other value is a synthesis-time error.
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  din holds a state to be substituted
- in_ready  output  1  block can accept din this cycle
- din  input  [0:7][0:7][7:0]  input state, row-major; byte index i = 8*row + col
- out_valid  output  1  dout holds a fully substituted state
- out_ready  input  1  downstream (ShiftBytes/MixBytes register) accepts dout
- dout  output  [0:7][0:7][7:0]  substituted state, same layout as din

## Operation
- N = 64/SBOX_COUNT substitution steps. Step counter cnt has width clog2(N), minimum 1 bit.
- A single 512-bit state register is updated in place. dout is driven directly from this register.
- State machine states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid → load din, cnt←0, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle, bytes i = cnt*SBOX_COUNT … cnt*SBOX_COUNT+SBOX_COUNT−1 are replaced by S(byte). All other bytes are held.
  - When cnt = N−1: the last group is written, cnt←0, go to DONE. Otherwise cnt←cnt+1.
- DONE:
  - out_valid=1, dout stable.
  - in_ready = out_ready (combinational).
  - out_ready & in_valid → load din, go to BUSY (back-to-back transfer, no bubble).
  - out_ready & !in_valid → go to IDLE.
  - !out_ready → hold everything, including dout, which must not change.
- S is the AES/Grøstl S-box: a GF(2^8) inverse modulo x^8+x^4+x^3+x+1, followed by the affine map with constant 0x63. It is implemented as SBOX_COUNT identical combinational instances (lookup table or composite-field logic).
- in_valid outside a handshake cycle is ignored. din is sampled only on the handshake edge.
- in_valid is not required to stay high, and din is not required to stay stable, after the handshake.

## Timing
- Reset values (register state after any clock edge with reset=1): state IDLE, cnt=0, state register=0. Resulting outputs: out_valid=0, dout=0, in_ready=1.
- Reset has priority over every other event and aborts BUSY or DONE mid-operation. The in-flight state is discarded and no out_valid is produced for it.
- Latency: handshake at edge t0 → out_valid high from the cycle after edge t0+N.
  - SBOX_COUNT=8: out_valid is seen N+1 = 9 cycles after in_valid&in_ready is sampled.
  - SBOX_COUNT=64: 2 cycles.
- Throughput with out_ready held high: one state per N+1 cycles.
- in_ready and out_valid are never both derived from BUSY. out_valid is a decode of the registered state only. in_ready depends combinationally on out_ready only in DONE.
- Byte groups are processed in ascending index order: row 0 first, column 0 first within a row.

## Test plan
- Reset, then din = all 0x00, in_valid for one cycle, out_ready=1 → out_valid after 9 cycles (SBOX_COUNT=8), every dout byte 0x63, then IDLE with in_ready=1.
- din byte i = i (0x00…0x3f) → dout bytes 0x63,0x7c,0x77,0x7b,… matching the AES S-box. Checked against a reference model for SBOX_COUNT=1, 8 and 64, with latencies 65, 9 and 2.
- din = 0x53 at row 2 / col 5 and 0xff elsewhere → dout 0xed at [2][5] and 0x16 elsewhere. With out_ready=0 for 20 cycles, out_valid and dout stay fixed and in_ready=0.
- DONE with out_ready=1 and in_valid=1 carrying a second state → the first state is accepted downstream and the second is loaded on the same edge. Second out_valid arrives N+1 cycles later with no idle cycle.
- reset pulsed at cnt=3 in BUSY → next cycle IDLE, out_valid=0, dout=0. A subsequent new state completes correctly with no residue from the aborted one.
- Random stimulus with random in_valid/out_ready stalls, 1000 states → every accepted state appears exactly once, in order, equal to the model's SubBytes.
